// File: rtl/pwm_pulse_decoder.sv
// rtl/pwm_pulse_decoder.sv - servo-style PWM pulse width/period decoder with glitch rejection and loss detect
module pwm_pulse_decoder #(
  parameter int TICK_DIV   = 50,
  parameter int MIN_US     = 1000,
  parameter int MAX_US     = 2000,
  parameter int TIMEOUT_US = 25000,
  parameter int GLITCH_US  = 500
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        PWMin,
  output logic [15:0] PulseWidth,
  output logic [15:0] Period,
  output logic [11:0] Setting,
  output logic        Valid,
  output logic        SignalLost,
  output logic [7:0]  GlitchCount
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(TICK_DIV - 1);
  localparam logic [15:0]      MIN_W      = 16'(MIN_US);
  localparam logic [15:0]      MAX_W      = 16'(MAX_US);
  localparam logic [15:0]      GLITCH_W   = 16'(GLITCH_US);
  localparam logic [15:0]      TIMEOUT_W  = 16'(TIMEOUT_US);
  localparam logic [16:0]      GLITCH_MAX = 17'(2 * MAX_US);
  localparam logic [16:0]      DEN        = 17'(MAX_US - MIN_US);
  localparam logic [4:0]       DIV_STEPS  = 5'd24;

  typedef enum logic [1:0] {
    WAIT_RISE = 2'd0,
    HIGH      = 2'd1,
    DIVIDE    = 2'd2
  } state_t;

  // Synchronizer chain; deliberately not reset so it keeps tracking the pin
  // through reset and no false rising edge appears when a pulse is in flight.
  logic [2:0] sync_q;
  always_ff @(posedge CLOCK_50) begin
    sync_q <= {sync_q[1:0], PWMin};
  end

  logic rise, fall, tick;
  assign rise = sync_q[1] & ~sync_q[2];
  assign fall = ~sync_q[1] & sync_q[2];

  state_t           state_q, state_d;
  logic [PRE_W-1:0] presc_q, presc_d;
  logic [15:0]      width_q, width_d, width_inc;
  logic [15:0]      per_q, per_d, per_inc;
  logic [15:0]      meas_q, meas_d;
  logic [23:0]      num_q, num_d;
  logic [15:0]      rem_q, rem_d;
  logic [23:0]      quot_q, quot_d;
  logic [4:0]       div_cnt_q, div_cnt_d;
  logic             pend_q, pend_d;
  logic             have_prev_q, have_prev_d;
  logic             lost_q, lost_d;
  logic [15:0]      pw_q, pw_d;
  logic [15:0]      period_q, period_d;
  logic [11:0]      setting_q, setting_d;
  logic             valid_q, valid_d;
  logic [7:0]       glitch_q, glitch_d;

  // Microsecond prescaler, period/timeout counter and loss-of-signal tracking.
  always_comb begin
    tick        = (presc_q == PRE_LAST);
    presc_d     = (rise || tick) ? '0 : presc_q + PRE_W'(1);
    width_inc   = (tick && width_q != 16'hFFFF) ? width_q + 16'd1 : width_q;
    per_inc     = (tick && per_q != 16'hFFFF) ? per_q + 16'd1 : per_q;
    per_d       = rise ? 16'd0 : per_inc;
    period_d    = period_q;
    have_prev_d = have_prev_q;
    lost_d      = lost_q;
    if (rise) begin
      if (have_prev_q) begin
        period_d = per_inc;
      end
      have_prev_d = 1'b1;
    end else if (per_inc >= TIMEOUT_W) begin
      lost_d      = 1'b1;
      have_prev_d = 1'b0;
    end
    // An accepted pulse always restores the signal, even on a coincident timeout.
    if (valid_d) begin
      lost_d = 1'b0;
    end
  end

  logic [16:0] rem_sh;
  logic [15:0] w_clamp;
  logic [15:0] w_off;
  logic [7:0]  glitch_inc;

  // Measurement FSM: width capture, glitch rejection and the serial divider.
  always_comb begin
    state_d    = state_q;
    width_d    = width_q;
    meas_d     = meas_q;
    num_d      = num_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    div_cnt_d  = div_cnt_q;
    pend_d     = pend_q;
    pw_d       = pw_q;
    setting_d  = setting_q;
    valid_d    = 1'b0;
    glitch_d   = glitch_q;
    glitch_inc = (glitch_q == 8'hFF) ? glitch_q : glitch_q + 8'd1;
    rem_sh     = {rem_q, num_q[23]};
    w_clamp    = (width_inc < MIN_W) ? MIN_W : ((width_inc > MAX_W) ? MAX_W : width_inc);
    w_off      = w_clamp - MIN_W;
    unique case (state_q)
      WAIT_RISE: begin
        if (rise) begin
          state_d = HIGH;
          width_d = 16'd0;
        end
      end
      HIGH: begin
        // The tick landing on the falling-edge cycle still belongs to the pulse.
        width_d = width_inc;
        if (fall) begin
          if (width_inc < GLITCH_W || {1'b0, width_inc} > GLITCH_MAX) begin
            glitch_d = glitch_inc;
            state_d  = WAIT_RISE;
          end else begin
            meas_d    = width_inc;
            // MAX_US - MIN_US is assumed below 4096 so the offset fits 12 bits.
            num_d     = {w_off[11:0], 12'd0};
            rem_d     = 16'd0;
            quot_d    = 24'd0;
            div_cnt_d = 5'd0;
            state_d   = DIVIDE;
          end
        end
      end
      DIVIDE: begin
        // A new pulse may start while dividing; start measuring it right away.
        if (rise) begin
          pend_d  = 1'b1;
          width_d = 16'd0;
        end else if (pend_q && fall) begin
          pend_d   = 1'b0;
          glitch_d = glitch_inc;
        end else if (pend_q) begin
          width_d = width_inc;
        end
        if (div_cnt_q != DIV_STEPS) begin
          if (rem_sh >= DEN) begin
            rem_d  = 16'(rem_sh - DEN);
            quot_d = {quot_q[22:0], 1'b1};
          end else begin
            rem_d  = rem_sh[15:0];
            quot_d = {quot_q[22:0], 1'b0};
          end
          num_d     = {num_q[22:0], 1'b0};
          div_cnt_d = div_cnt_q + 5'd1;
        end else begin
          pw_d      = meas_q;
          setting_d = (quot_q > 24'd4095) ? 12'hFFF : quot_q[11:0];
          valid_d   = 1'b1;
          state_d   = pend_d ? HIGH : WAIT_RISE;
          pend_d    = 1'b0;
        end
      end
      default: begin
        state_d = WAIT_RISE;
      end
    endcase
  end

  // State registers with synchronous reset; a reset mid-pulse discards it.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= WAIT_RISE;
      presc_q     <= '0;
      width_q     <= 16'd0;
      per_q       <= 16'd0;
      meas_q      <= 16'd0;
      num_q       <= 24'd0;
      rem_q       <= 16'd0;
      quot_q      <= 24'd0;
      div_cnt_q   <= 5'd0;
      pend_q      <= 1'b0;
      have_prev_q <= 1'b0;
      lost_q      <= 1'b0;
      pw_q        <= 16'd0;
      period_q    <= 16'd0;
      setting_q   <= 12'd0;
      valid_q     <= 1'b0;
      glitch_q    <= 8'd0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      width_q     <= width_d;
      per_q       <= per_d;
      meas_q      <= meas_d;
      num_q       <= num_d;
      rem_q       <= rem_d;
      quot_q      <= quot_d;
      div_cnt_q   <= div_cnt_d;
      pend_q      <= pend_d;
      have_prev_q <= have_prev_d;
      lost_q      <= lost_d;
      pw_q        <= pw_d;
      period_q    <= period_d;
      setting_q   <= setting_d;
      valid_q     <= valid_d;
      glitch_q    <= glitch_d;
    end
  end

  assign PulseWidth  = pw_q;
  assign Period      = period_q;
  assign Setting     = lost_q ? 12'd0 : setting_q;
  assign Valid       = valid_q;
  assign SignalLost  = lost_q;
  assign GlitchCount = glitch_q;

endmodule

// File: tb/tb_pwm_pulse_decoder.sv
// tb/tb_pwm_pulse_decoder.sv - scoreboard testbench for pwm_pulse_decoder
module tb_pwm_pulse_decoder;

  localparam int TICK_DIV   = 2;
  localparam int MIN_US     = 100;
  localparam int MAX_US     = 200;
  localparam int TIMEOUT_US = 2500;
  localparam int GLITCH_US  = 50;
  localparam int VALID_LAT  = 28;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pwm = 1'b0;
  logic [15:0] PulseWidth;
  logic [15:0] Period;
  logic [11:0] Setting;
  logic        Valid;
  logic        SignalLost;
  logic [7:0]  GlitchCount;

  pwm_pulse_decoder #(
    .TICK_DIV(TICK_DIV), .MIN_US(MIN_US), .MAX_US(MAX_US),
    .TIMEOUT_US(TIMEOUT_US), .GLITCH_US(GLITCH_US)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .PWMin(pwm),
    .PulseWidth(PulseWidth), .Period(Period), .Setting(Setting),
    .Valid(Valid), .SignalLost(SignalLost), .GlitchCount(GlitchCount)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int pw;
    int setting;
    int at;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;
  int exp_glitch = 0;
  int exp_period = 0;
  int prev_valid = 0;
  int prev_len = 0;
  int last_pw = 0;
  int last_set = 0;
  int rise_cyc = 0;

  function automatic int model_setting(input int w);
    int wc;
    int v;
    wc = (w < MIN_US) ? MIN_US : ((w > MAX_US) ? MAX_US : w);
    v = ((wc - MIN_US) * 4096) / (MAX_US - MIN_US);
    return (v > 4095) ? 4095 : v;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (Valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_valid at cycle %0d PulseWidth=%0d Setting=%0d", cyc, PulseWidth, Setting);
      end else begin
        e = sb.pop_front();
        checks += 2;
        if (PulseWidth !== 16'(e.pw)) begin
          failures++;
          $display("FAIL valid_pulsewidth got=%0d exp=%0d", PulseWidth, e.pw);
        end
        if (Setting !== 12'(e.setting)) begin
          failures++;
          $display("FAIL valid_setting got=%0d exp=%0d", Setting, e.setting);
        end
        if (cyc !== e.at) begin
          failures++;
          $display("FAIL valid_latency got_cycle=%0d exp_cycle=%0d", cyc, e.at);
        end
      end
    end
  end

  // Caller sits just after a rising clock edge; input is high high_cyc cycles, then low low_cyc cycles.
  task automatic drive_pulse(input int high_cyc, input int low_cyc);
    int w;
    exp_t e;
    pwm = 1'b1;
    rise_cyc = cyc;
    if (prev_valid != 0) exp_period = (prev_len / TICK_DIV > 65535) ? 65535 : prev_len / TICK_DIV;
    prev_valid = 1;
    prev_len = high_cyc + low_cyc;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (Period !== 16'(exp_period)) begin
      failures++;
      $display("FAIL period got=%0d exp=%0d", Period, exp_period);
    end
    repeat (high_cyc - 4) @(posedge clk);
    #1;
    pwm = 1'b0;
    w = high_cyc / TICK_DIV;
    if (w < GLITCH_US || w > 2 * MAX_US) begin
      exp_glitch = (exp_glitch == 255) ? 255 : exp_glitch + 1;
    end else begin
      e.pw = w;
      e.setting = model_setting(w);
      e.at = cyc + VALID_LAT;
      last_pw = w;
      last_set = e.setting;
      sb.push_back(e);
    end
    repeat (low_cyc) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s missing_valid got_pending=%0d exp_pending=0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_zero_outputs(input string name);
    checks += 6;
    if (PulseWidth !== 16'd0) begin failures++; $display("FAIL %s PulseWidth got=%0d exp=0", name, PulseWidth); end
    if (Period !== 16'd0) begin failures++; $display("FAIL %s Period got=%0d exp=0", name, Period); end
    if (Setting !== 12'd0) begin failures++; $display("FAIL %s Setting got=%0d exp=0", name, Setting); end
    if (Valid !== 1'b0) begin failures++; $display("FAIL %s Valid got=%0b exp=0", name, Valid); end
    if (SignalLost !== 1'b0) begin failures++; $display("FAIL %s SignalLost got=%0b exp=0", name, SignalLost); end
    if (GlitchCount !== 8'd0) begin failures++; $display("FAIL %s GlitchCount got=%0d exp=0", name, GlitchCount); end
  endtask

  task automatic model_reset();
    exp_glitch = 0;
    exp_period = 0;
    prev_valid = 0;
    last_pw = 0;
    last_set = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pwm = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_zero_outputs("reset");
  endtask

  task automatic test_basic();
    drive_pulse(300, 3700);
    drive_pulse(300, 3700);
    drive_pulse(301, 699);
    wait_drain("basic");
  endtask

  task automatic test_settings();
    drive_pulse(200, 400);
    drive_pulse(400, 400);
    drive_pulse(480, 400);
    drive_pulse(198, 400);
    wait_drain("settings");
  endtask

  task automatic test_glitch();
    drive_pulse(60, 400);
    drive_pulse(1000, 400);
    checks += 3;
    if (GlitchCount !== 8'(exp_glitch)) begin failures++; $display("FAIL glitch_count got=%0d exp=%0d", GlitchCount, exp_glitch); end
    if (PulseWidth !== 16'(last_pw)) begin failures++; $display("FAIL glitch_pw_hold got=%0d exp=%0d", PulseWidth, last_pw); end
    if (Setting !== 12'(last_set)) begin failures++; $display("FAIL glitch_set_hold got=%0d exp=%0d", Setting, last_set); end
    drive_pulse(100, 400);
    drive_pulse(800, 400);
    wait_drain("glitch_bounds");
    checks++;
    if (GlitchCount !== 8'(exp_glitch)) begin failures++; $display("FAIL glitch_bounds_count got=%0d exp=%0d", GlitchCount, exp_glitch); end
  endtask

  task automatic test_timeout();
    int t0;
    int held_period;
    drive_pulse(300, 100);
    wait_drain("timeout_train");
    t0 = rise_cyc;
    while (cyc < t0 + TIMEOUT_US * TICK_DIV - 20) @(posedge clk);
    #1;
    checks++;
    if (SignalLost !== 1'b0) begin failures++; $display("FAIL lost_early got=%0b exp=0", SignalLost); end
    while (cyc < t0 + TIMEOUT_US * TICK_DIV + 30) @(posedge clk);
    #1;
    checks += 3;
    if (SignalLost !== 1'b1) begin failures++; $display("FAIL lost_set got=%0b exp=1", SignalLost); end
    if (Setting !== 12'd0) begin failures++; $display("FAIL lost_setting got=%0d exp=0", Setting); end
    if (PulseWidth !== 16'(last_pw)) begin failures++; $display("FAIL lost_pw_hold got=%0d exp=%0d", PulseWidth, last_pw); end
    prev_valid = 0;
    held_period = exp_period;
    drive_pulse(240, 400);
    wait_drain("recover");
    checks += 2;
    if (SignalLost !== 1'b0) begin failures++; $display("FAIL lost_clear got=%0b exp=0", SignalLost); end
    if (Period !== 16'(held_period)) begin failures++; $display("FAIL lost_period_hold got=%0d exp=%0d", Period, held_period); end
  endtask

  task automatic test_reset_mid_pulse();
    pwm = 1'b1;
    repeat (140) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_zero_outputs("reset_mid");
    repeat (160) @(posedge clk);
    #1;
    pwm = 1'b0;
    repeat (400) @(posedge clk);
    #1;
    check_zero_outputs("reset_partial");
    drive_pulse(300, 400);
    wait_drain("after_reset");
  endtask

  task automatic test_back_to_back();
    drive_pulse(360, 10);
    drive_pulse(360, 400);
    wait_drain("back_to_back");
    checks++;
    if (GlitchCount !== 8'(exp_glitch)) begin failures++; $display("FAIL b2b_glitch got=%0d exp=%0d", GlitchCount, exp_glitch); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_settings();
    test_glitch();
    test_timeout();
    test_reset_mid_pulse();
    test_back_to_back();
    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
